// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Conditions the raw push-button lines that feed the game datapath. Each line
// is synchronised and debounced independently. A small FSM then guarantees
// that the vector handed downstream is always all-zero or exactly one-hot.
// It also produces one-cycle press/release pulses and flags illegal
// multi-button presses.
//
// Ports
//   clock          in   1         system clock, rising edge
//   reset          in   1         asynchronous, active-low reset
//   botoes_brutos  in   N_BOTOES  raw button levels, active-high, asynchronous
//   botoes_limpos  out  N_BOTOES  conditioned vector, zero or one-hot
//   pressionado    out  1         one-cycle pulse on zero -> one-hot
//   liberado       out  1         one-cycle pulse on one-hot -> zero
//   multiplo       out  1         high while an illegal multi-press is active
//   db_estado      out  2         FSM state (00 SOLTO, 01 UNICO, 10 INVALIDO)
// -----------------------------------------------------------------------------
module condicionador_botoes #(
    parameter int N_BOTOES = 7,
    parameter int DEBOUNCE = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_brutos,
    output logic [N_BOTOES-1:0] botoes_limpos,
    output logic                pressionado,
    output logic                liberado,
    output logic                multiplo,
    output logic [1:0]          db_estado
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_UM   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);
    localparam logic [N_BOTOES-1:0] VEC_ZERO = '0;
    localparam logic [N_BOTOES-1:0] VEC_UM   = N_BOTOES'(1);

    // The encoding doubles as the debug output.
    typedef enum logic [1:0] {
        SOLTO    = 2'b00,
        UNICO    = 2'b01,
        INVALIDO = 2'b10
    } estado_t;

    logic [N_BOTOES-1:0] r_sinc_a;
    logic [N_BOTOES-1:0] r_sinc;
    logic [N_BOTOES-1:0] r_estavel;
    logic [CW-1:0]       r_cnt [N_BOTOES];
    estado_t             r_estado;
    logic [N_BOTOES-1:0] r_limpos;
    logic                r_press;
    logic                r_lib;
    logic                r_mult;

    // True when exactly one bit of the vector is set.
    function automatic logic f_um_bit(input logic [N_BOTOES-1:0] v);
        return (v != VEC_ZERO) && ((v & (v - VEC_UM)) == VEC_ZERO);
    endfunction

    // Two-flop synchroniser for the asynchronous button lines.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinc_a <= VEC_ZERO;
            r_sinc   <= VEC_ZERO;
        end else begin
            r_sinc_a <= botoes_brutos;
            r_sinc   <= r_sinc_a;
        end
    end

    // Per-bit debounce: a new level is accepted only after it has held for
    // DEBOUNCE consecutive cycles; any return to the old level restarts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estavel <= VEC_ZERO;
            for (int i = 0; i < N_BOTOES; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < N_BOTOES; i++) begin
                if (r_sinc[i] == r_estavel[i]) begin
                    r_cnt[i] <= CNT_ZERO;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_estavel[i] <= r_sinc[i];
                    r_cnt[i]     <= CNT_ZERO;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_UM;
                end
            end
        end
    end

    // Press-validation FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= SOLTO;
            r_limpos <= VEC_ZERO;
            r_press  <= 1'b0;
            r_lib    <= 1'b0;
            r_mult   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            r_lib   <= 1'b0;
            case (r_estado)
                SOLTO: begin
                    if (r_estavel == VEC_ZERO) begin
                        r_estado <= SOLTO;
                    end else if (f_um_bit(r_estavel)) begin
                        r_estado <= UNICO;
                        r_limpos <= r_estavel;
                        r_press  <= 1'b1;
                    end else begin
                        r_estado <= INVALIDO;
                        r_mult   <= 1'b1;
                    end
                end
                UNICO: begin
                    if (r_estavel == r_limpos) begin
                        r_estado <= UNICO;
                    end else if (r_estavel == VEC_ZERO) begin
                        r_estado <= SOLTO;
                        r_limpos <= VEC_ZERO;
                        r_lib    <= 1'b1;
                    end else begin
                        // Extra bit or a same-cycle swap is never a clean press.
                        r_estado <= INVALIDO;
                        r_limpos <= VEC_ZERO;
                        r_mult   <= 1'b1;
                    end
                end
                INVALIDO: begin
                    // Only a full release clears the fault; a leftover single
                    // button must not turn into a press.
                    if (r_estavel == VEC_ZERO) begin
                        r_estado <= SOLTO;
                        r_mult   <= 1'b0;
                    end else begin
                        r_estado <= INVALIDO;
                    end
                end
                default: begin
                    r_estado <= SOLTO;
                    r_limpos <= VEC_ZERO;
                    r_mult   <= 1'b0;
                end
            endcase
        end
    end

    assign botoes_limpos = r_limpos;
    assign pressionado   = r_press;
    assign liberado      = r_lib;
    assign multiplo      = r_mult;
    assign db_estado     = r_estado;

endmodule
